shift_pattern_decoder: RTL and testbench



---
 rtl/shift_pkg.sv | 32 +++
 rtl/shift_pattern_decoder_if.sv | 22 ++
 rtl/johnson_decode.sv | 13 +
 rtl/shift_pattern_decoder.sv | 119 +++++++++++
 tb/tb_shift_pattern_decoder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types, sizes and Johnson code helpers for the pattern decoder
package shift_pkg;

  localparam int WIDTH   = 8;
  localparam int SEQ_LEN = 2 * WIDTH;
  localparam int IDXW    = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  typedef logic [WIDTH-1:0] pat_t;
  typedef logic [IDXW-1:0]  idx_t;

  // Legal when the ones (or the zeros) form one run anchored at the LSB.
  function automatic logic is_johnson(input pat_t p);
    pat_t np;
    np = ~p;
    return ((p & (p + pat_t'(1))) == '0) || ((np & (np + pat_t'(1))) == '0);
  endfunction

  function automatic idx_t johnson_index(input pat_t p);
    int ones;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones += int'(p[i]);
    end
    if ((p == '0) || p[0]) begin
      return idx_t'(ones);
    end
    return idx_t'(SEQ_LEN - ones);
  endfunction

endpackage

// File: rtl/shift_pattern_decoder_if.sv
// rtl/shift_pattern_decoder_if.sv - pattern input and decoded status bundle
interface shift_pattern_decoder_if;
  import shift_pkg::*;

  pat_t       pattern;
  logic       sample;
  idx_t       index;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  modport master (
    output pattern, sample,
    input  index, locked, err, err_count
  );

  modport slave (
    input  pattern, sample,
    output index, locked, err, err_count
  );

endinterface

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational legality check and phase decode of one pattern
module johnson_decode
  import shift_pkg::*;
(
  input  pat_t pattern_i,
  output logic legal_o,
  output idx_t idx_o
);

  assign legal_o = is_johnson(pattern_i);
  assign idx_o   = johnson_index(pattern_i);

endmodule

// File: rtl/shift_pattern_decoder.sv
// rtl/shift_pattern_decoder.sv - locks onto a Johnson sequence and flags illegal or out-of-order samples
module shift_pattern_decoder
  import shift_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_pattern_decoder_if.slave bus
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  typedef logic [CW-1:0] confirm_t;
  typedef logic [MW-1:0] miss_t;

  state_t     state_q;
  idx_t       prev_q;
  idx_t       index_q;
  logic       locked_q;
  logic       err_q;
  logic [7:0] err_count_q;
  confirm_t   confirm_q;
  miss_t      miss_q;

  logic legal;
  idx_t idx;
  idx_t exp_idx;
  logic is_succ;
  logic is_hold;

  johnson_decode u_decode (
    .pattern_i (bus.pattern),
    .legal_o   (legal),
    .idx_o     (idx)
  );

  assign exp_idx = (prev_q == idx_t'(SEQ_LEN - 1)) ? '0 : prev_q + idx_t'(1);
  assign is_succ = legal && (idx == exp_idx);
  assign is_hold = legal && (idx == prev_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      index_q     <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      confirm_q   <= '0;
      miss_q      <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.sample) begin
        case (state_q)
          HUNT: begin
            if (legal) begin
              prev_q    <= idx;
              index_q   <= idx;
              confirm_q <= '0;
              state_q   <= VERIFY;
            end
          end
          VERIFY: begin
            if (!legal) begin
              state_q <= HUNT;
            end else if (is_succ) begin
              prev_q    <= idx;
              index_q   <= idx;
              confirm_q <= confirm_q + confirm_t'(1);
              if (confirm_q == confirm_t'(LOCK_CNT - 1)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else if (!is_hold) begin
              prev_q    <= idx;
              index_q   <= idx;
              confirm_q <= '0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              prev_q  <= idx;
              index_q <= idx;
              miss_q  <= '0;
            end else if (!is_hold) begin
              err_q <= 1'b1;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
              // A legal wrong step resyncs the expected successor; illegal codes leave it alone.
              if (legal) begin
                prev_q  <= idx;
                index_q <= idx;
              end
              if (miss_q == miss_t'(LOSS_CNT - 1)) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                miss_q   <= '0;
              end else begin
                miss_q <= miss_q + miss_t'(1);
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.index     = index_q;
  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_shift_pattern_decoder.sv
// tb/tb_shift_pattern_decoder.sv - directed and randomized checks of the Johnson pattern decoder
module tb_shift_pattern_decoder;

  localparam int LOCK = 3;
  localparam int LOSS = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int m_state = 0;
  int m_prev = 0;
  int m_index = 0;
  int m_locked = 0;
  int m_err = 0;
  int m_cnt = 0;
  int m_confirm = 0;
  int m_miss = 0;

  shift_pattern_decoder_if bus ();

  shift_pattern_decoder #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Phase k of an 8-bit twisted ring: k ones fill from the LSB, then zeros fill from the LSB.
  function automatic logic [7:0] code_of(input int k);
    if (k <= 8) return 8'((16'd1 << k) - 16'd1);
    return ~8'((16'd1 << (k - 8)) - 16'd1);
  endfunction

  function automatic int phase_of(input logic [7:0] p);
    for (int k = 0; k < 16; k++) begin
      if (code_of(k) == p) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] p, input logic s, input logic r);
    int k;
    int nxt;
    m_err = 0;
    if (r) begin
      m_state = 0; m_prev = 0; m_index = 0; m_locked = 0;
      m_cnt = 0; m_confirm = 0; m_miss = 0;
      return;
    end
    if (!s) return;
    k = phase_of(p);
    nxt = (m_prev + 1) % 16;
    if (m_state == 0) begin
      if (k >= 0) begin m_prev = k; m_index = k; m_confirm = 0; m_state = 1; end
    end else if (m_state == 1) begin
      if (k < 0) m_state = 0;
      else if (k == nxt) begin
        m_prev = k; m_index = k; m_confirm++;
        if (m_confirm == LOCK) begin m_state = 2; m_locked = 1; m_miss = 0; end
      end else if (k != m_prev) begin
        m_prev = k; m_index = k; m_confirm = 0;
      end
    end else begin
      if (k == nxt) begin
        m_prev = k; m_index = k; m_miss = 0;
      end else if (!(k >= 0 && k == m_prev)) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
        if (k >= 0) begin m_prev = k; m_index = k; end
        m_miss++;
        if (m_miss == LOSS) begin m_state = 0; m_locked = 0; m_miss = 0; end
      end
    end
  endtask

  task automatic step(input logic [7:0] p, input logic s);
    bus.pattern = p;
    bus.sample  = s;
    @(posedge clk);
    #1;
    model_step(p, s, reset);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(8'h00, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(8'h3F, 1'b1);
      checks++;
      if (bus.index !== 4'd0 || bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.err_count !== 8'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: index=%0d locked=%b err=%b cnt=%0d, want all 0", c, bus.index, bus.locked, bus.err, bus.err_count);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_lock_wrap();
    do_reset();
    step(8'h00, 1'b1);
    step(8'h01, 1'b1);
    step(8'h03, 1'b1);
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL early_lock: locked=%b want 0", bus.locked);
    end
    step(8'h07, 1'b1);
    checks++;
    if (bus.locked !== 1'b1 || bus.index !== 4'd3) begin
      errors++;
      $display("FAIL lock: locked=%b index=%0d want 1/3", bus.locked, bus.index);
    end
    for (int k = 4; k <= 16; k++) begin
      step(code_of(k % 16), 1'b1);
      checks++;
      if (bus.index !== 4'(k % 16) || bus.err !== 1'b0 || bus.locked !== 1'b1) begin
        errors++;
        $display("FAIL wrap k=%0d: index=%0d err=%b locked=%b want %0d/0/1", k, bus.index, bus.err, bus.locked, k % 16);
      end
    end
  endtask

  task automatic test_illegal_locked();
    step(8'h05, 1'b1);
    checks++;
    if (bus.err !== 1'b1 || bus.err_count !== 8'd1 || bus.index !== 4'd0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL illegal: err=%b cnt=%0d index=%0d locked=%b want 1/1/0/1", bus.err, bus.err_count, bus.index, bus.locked);
    end
    step(8'hFF, 1'b0);
    checks++;
    if (bus.err !== 1'b0 || bus.index !== 4'd0) begin
      errors++;
      $display("FAIL idle: err=%b index=%0d want 0/0", bus.err, bus.index);
    end
    step(8'h01, 1'b1);
    checks++;
    if (bus.err !== 1'b0 || bus.index !== 4'd1) begin
      errors++;
      $display("FAIL resync: err=%b index=%0d want 0/1", bus.err, bus.index);
    end
    step(8'h05, 1'b1);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 8'd2) begin
      errors++;
      $display("FAIL miss_clear: locked=%b cnt=%0d want 1/2", bus.locked, bus.err_count);
    end
    step(8'h03, 1'b1);
  endtask

  task automatic test_loss();
    do_reset();
    step(8'h00, 1'b1); step(8'h01, 1'b1); step(8'h03, 1'b1); step(8'h07, 1'b1);
    step(8'h05, 1'b1);
    checks++;
    if (bus.err !== 1'b1 || bus.err_count !== 8'd1 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL loss1: err=%b cnt=%0d locked=%b want 1/1/1", bus.err, bus.err_count, bus.locked);
    end
    step(8'h09, 1'b1);
    checks++;
    if (bus.err !== 1'b1 || bus.err_count !== 8'd2 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL loss2: err=%b cnt=%0d locked=%b want 1/2/0", bus.err, bus.err_count, bus.locked);
    end
    step(8'h05, 1'b1);
    checks++;
    if (bus.err !== 1'b0 || bus.err_count !== 8'd2) begin
      errors++;
      $display("FAIL hunt_illegal: err=%b cnt=%0d want 0/2", bus.err, bus.err_count);
    end
    step(8'h0F, 1'b1);
    checks++;
    if (bus.index !== 4'd4 || bus.locked !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL hunt_legal: index=%0d locked=%b err=%b want 4/0/0", bus.index, bus.locked, bus.err);
    end
  endtask

  task automatic test_hold_skip();
    do_reset();
    step(8'h01, 1'b1); step(8'h03, 1'b1); step(8'h07, 1'b1); step(8'h0F, 1'b1);
    step(8'h0F, 1'b1);
    checks++;
    if (bus.err !== 1'b0 || bus.index !== 4'd4 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL hold: err=%b index=%0d locked=%b want 0/4/1", bus.err, bus.index, bus.locked);
    end
    step(8'h3F, 1'b1);
    checks++;
    if (bus.err !== 1'b1 || bus.index !== 4'd6 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL skip: err=%b index=%0d locked=%b want 1/6/1", bus.err, bus.index, bus.locked);
    end
    step(8'h7F, 1'b1);
    checks++;
    if (bus.err !== 1'b0 || bus.index !== 4'd7) begin
      errors++;
      $display("FAIL after_skip: err=%b index=%0d want 0/7", bus.err, bus.index);
    end
    step(8'h05, 1'b1);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL skip_miss_clear: locked=%b want 1", bus.locked);
    end
  endtask

  task automatic test_saturation_reset();
    int nxt;
    do_reset();
    step(8'h00, 1'b1); step(8'h01, 1'b1); step(8'h03, 1'b1); step(8'h07, 1'b1);
    nxt = 4;
    for (int i = 1; i <= 300; i++) begin
      step(8'h05, 1'b1);
      if (i == 254 || i == 255 || i == 300) begin
        checks++;
        if (bus.err_count !== 8'(i > 255 ? 255 : i) || bus.err !== 1'b1) begin
          errors++;
          $display("FAIL sat i=%0d: cnt=%0d err=%b want %0d/1", i, bus.err_count, bus.err, i > 255 ? 255 : i);
        end
      end
      step(code_of(nxt), 1'b1);
      nxt = (nxt + 1) % 16;
    end
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_end: locked=%b cnt=%0d want 1/255", bus.locked, bus.err_count);
    end
    reset = 1'b1;
    step(code_of(nxt), 1'b1);
    reset = 1'b0;
    checks++;
    if (bus.index !== 4'd0 || bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: index=%0d locked=%b err=%b cnt=%0d want all 0", bus.index, bus.locked, bus.err, bus.err_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic       s;
    int         r;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)       p = code_of((m_prev + 1) % 16);
      else if (r == 5) p = code_of(m_prev);
      else if (r == 6) p = code_of(int'($urandom_range(0, 15)));
      else             p = 8'($urandom);
      s = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 149) == 0);
      step(p, s);
      checks++;
      if (bus.index !== 4'(m_index) || bus.locked !== 1'(m_locked) || bus.err !== 1'(m_err) || bus.err_count !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL random n=%0d p=%h s=%b: index=%0d locked=%b err=%b cnt=%0d want %0d/%0d/%0d/%0d",
                 n, p, s, bus.index, bus.locked, bus.err, bus.err_count, m_index, m_locked, m_err, m_cnt);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.pattern = 8'h00;
    bus.sample  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lock_wrap();
    test_illegal_locked();
    test_loss();
    test_hold_skip();
    test_saturation_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
